// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the queued UART transmitter: parity modes, FSM
// state encoding and the parity helper used when a word is loaded.
package uart_tx_fifo_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] word, input logic [1:0] mode);
        logic x;
        x = ^word;
        if (mode == PARITY_ODD) begin
            parity_bit = ~x;
        end else begin
            parity_bit = x;
        end
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Upstream write port and serial-side status of the queued UART transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx;
    logic                 busy;
    logic                 fifo_full;
    logic                 overflow;
    logic                 tx_done;

    modport master (
        output tx_start, data_in,
        input  tx, busy, fifo_full, overflow, tx_done
    );

    modport slave (
        input  tx_start, data_in,
        output tx, busy, fifo_full, overflow, tx_done
    );
endinterface

// File: rtl/uart_tx_fifo_fifo.sv
// Synchronous FIFO with a registered occupancy count; the head word is
// presented combinationally so the consumer can load it in the pop cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign rd_data = mem_r[rd_ptr_r];

    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign wr_ok_s = wr_en && (!full || rd_en);
    assign rd_ok_s = rd_en && !empty;

    // Storage array; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Queued UART transmitter: configurable width, parity and stop bits, frames
// sent back-to-back LSB first from an input FIFO. All outputs are registered.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [1:0]        PAR_MODE  = 2'(PARITY);

    state_t                 state_r,  state_nxt_s;
    logic [BAUD_W-1:0]      baud_r,   baud_nxt_s;
    logic [3:0]             bit_r,    bit_nxt_s;
    logic [DATA_BITS-1:0]   shift_r,  shift_nxt_s;
    logic                   par_r,    par_nxt_s;
    logic                   tx_r,     tx_nxt_s;
    logic                   busy_r,   busy_nxt_s;
    logic                   done_r,   done_nxt_s;
    logic                   ovf_r,    ovf_nxt_s;
    logic                   pop_s;
    logic                   wr_s;
    logic                   baud_last_s;
    logic [DATA_BITS-1:0]   fifo_rd_data_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_s),
        .wr_data (bus.data_in),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign baud_last_s   = (baud_r == BAUD_LAST);
    assign bus.tx        = tx_r;
    assign bus.busy      = busy_r;
    assign bus.fifo_full = fifo_full_s;
    assign bus.overflow  = ovf_r;
    assign bus.tx_done   = done_r;

    // Next-state, counters and the registered-output values derived from the next state.
    always_comb begin
        state_nxt_s = state_r;
        baud_nxt_s  = baud_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        par_nxt_s   = par_r;
        pop_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_START;
                    baud_nxt_s  = '0;
                    bit_nxt_s   = 4'd0;
                    shift_nxt_s = fifo_rd_data_s;
                    par_nxt_s   = parity_bit(9'(fifo_rd_data_s), PAR_MODE);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    state_nxt_s = ST_DATA;
                    baud_nxt_s  = '0;
                    bit_nxt_s   = 4'd0;
                end else begin
                    baud_nxt_s = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_nxt_s = '0;
                    if (bit_r == DATA_LAST) begin
                        bit_nxt_s = 4'd0;
                        if (PAR_MODE != PARITY_NONE) begin
                            state_nxt_s = ST_PARITY;
                        end else begin
                            state_nxt_s = ST_STOP;
                        end
                    end else begin
                        bit_nxt_s   = bit_r + 4'd1;
                        shift_nxt_s = shift_r >> 1;
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_W'(1);
                end
            end
            ST_PARITY: begin
                if (baud_last_s) begin
                    state_nxt_s = ST_STOP;
                    baud_nxt_s  = '0;
                    bit_nxt_s   = 4'd0;
                end else begin
                    baud_nxt_s = baud_r + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_nxt_s = '0;
                    if (bit_r == STOP_LAST) begin
                        bit_nxt_s = 4'd0;
                        // Popping in the final stop cycle keeps frames gap-free.
                        if (!fifo_empty_s) begin
                            pop_s       = 1'b1;
                            state_nxt_s = ST_START;
                            shift_nxt_s = fifo_rd_data_s;
                            par_nxt_s   = parity_bit(9'(fifo_rd_data_s), PAR_MODE);
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        bit_nxt_s = bit_r + 4'd1;
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                baud_nxt_s  = '0;
                bit_nxt_s   = 4'd0;
            end
        endcase

        case (state_nxt_s)
            ST_IDLE:   tx_nxt_s = 1'b1;
            ST_START:  tx_nxt_s = 1'b0;
            ST_DATA:   tx_nxt_s = shift_nxt_s[0];
            ST_PARITY: tx_nxt_s = par_nxt_s;
            ST_STOP:   tx_nxt_s = 1'b1;
            default:   tx_nxt_s = 1'b1;
        endcase

        wr_s       = bus.tx_start && (!fifo_full_s || pop_s);
        ovf_nxt_s  = bus.tx_start && fifo_full_s && !pop_s;
        // IDLE as next state implies the FIFO is drained, so only a fresh write keeps busy up.
        busy_nxt_s = wr_s || (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_STOP) && (baud_nxt_s == BAUD_LAST) &&
                     (bit_nxt_s == STOP_LAST);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            bit_r   <= 4'd0;
            shift_r <= '0;
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            baud_r  <= baud_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            par_r   <= par_nxt_s;
            tx_r    <= tx_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations driven from a write schedule and
// compared cycle by cycle against a frame-timeline model of the transmitter.
module tb_uart_tx_fifo;

    localparam int CLKS  = 16;
    localparam int DEPTH = 4;
    localparam int MAXC  = 4000;
    localparam int MAXW  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drv_start = 1'b0;
    logic [8:0] drv_data = 9'd0;
    int         sel = 0;
    int         errors = 0;
    int         checks = 0;

    int         wr_cyc  [MAXW];
    int         wr_word [MAXW];
    int         n_wr;
    logic [4:0] exp_v [MAXC];   // {tx, busy, fifo_full, overflow, tx_done}
    int         horizon;
    logic [4:0] obs;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_e ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_o ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if_s ();

    assign if_a.tx_start = drv_start && (sel == 0);
    assign if_e.tx_start = drv_start && (sel == 1);
    assign if_o.tx_start = drv_start && (sel == 2);
    assign if_s.tx_start = drv_start && (sel == 3);
    assign if_a.data_in  = drv_data[7:0];
    assign if_e.data_in  = drv_data[7:0];
    assign if_o.data_in  = drv_data[7:0];
    assign if_s.data_in  = drv_data[6:0];

    uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        u_e (.clk(clk), .rst(rst), .bus(if_e.slave));
    uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        u_o (.clk(clk), .rst(rst), .bus(if_o.slave));
    uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
        u_s (.clk(clk), .rst(rst), .bus(if_s.slave));

    always_comb begin
        case (sel)
            1:       obs = {if_e.tx, if_e.busy, if_e.fifo_full, if_e.overflow, if_e.tx_done};
            2:       obs = {if_o.tx, if_o.busy, if_o.fifo_full, if_o.overflow, if_o.tx_done};
            3:       obs = {if_s.tx, if_s.busy, if_s.fifo_full, if_s.overflow, if_s.tx_done};
            default: obs = {if_a.tx, if_a.busy, if_a.fifo_full, if_a.overflow, if_a.tx_done};
        endcase
    end

    // Timeline model: a word written in cycle w starts its frame at max(w+2, end of previous frame).
    function automatic void build_model(input int dbits, input int par, input int stops);
        int fl, nb, nfree, qn, st, w, occ, word, bv, last;
        int acc_w [MAXW];
        int pop_c [MAXW];
        fl    = CLKS * (1 + dbits + ((par != 0) ? 1 : 0) + stops);
        nb    = fl / CLKS;
        nfree = 0;
        qn    = 0;
        last  = 0;
        for (int c = 0; c < MAXC; c++) exp_v[c] = 5'b10000;
        for (int i = 0; i < n_wr; i++) begin
            w   = wr_cyc[i];
            occ = 0;
            for (int j = 0; j < qn; j++) if (acc_w[j] < w && pop_c[j] > w) occ++;
            if (occ < DEPTH) begin
                st    = (w + 2 > nfree) ? w + 2 : nfree;
                nfree = st + fl;
                acc_w[qn] = w;
                pop_c[qn] = st - 1;
                qn++;
                word = wr_word[i] & ((1 << dbits) - 1);
                for (int b = 0; b < nb; b++) begin
                    if (b == 0) bv = 0;
                    else if (b <= dbits) bv = (word >> (b - 1)) & 1;
                    else if (par != 0 && b == dbits + 1)
                        bv = (par == 2) ? ($countones(word) % 2) : (1 - ($countones(word) % 2));
                    else bv = 1;
                    for (int k = 0; k < CLKS; k++) exp_v[st + b * CLKS + k][4] = (bv != 0);
                end
                for (int c = w + 1; c < st + fl; c++) exp_v[c][3] = 1'b1;
                exp_v[st + fl - 1][0] = 1'b1;
                if (st + fl > last) last = st + fl;
            end else begin
                exp_v[w + 1][1] = 1'b1;
            end
            if (w + 2 > last) last = w + 2;
        end
        for (int c = 0; c < last; c++) begin
            occ = 0;
            for (int j = 0; j < qn; j++) if (acc_w[j] < c && pop_c[j] >= c) occ++;
            exp_v[c][2] = (occ == DEPTH);
        end
        horizon = last + 4;
    endfunction

    task automatic apply_inputs(input int c);
        drv_start = 1'b0;
        for (int i = 0; i < n_wr; i++) begin
            if (wr_cyc[i] == c) begin
                drv_start = 1'b1;
                drv_data  = 9'(wr_word[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            checks++;
            if (obs !== 5'b10000) begin
                errors++;
                $display("FAIL reset_state inst=%0d got %b expected 10000", s, obs);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sel = 0;
    endtask

    task automatic test_8n1();
        sel = 0; n_wr = 1; wr_cyc[0] = 0; wr_word[0] = 'h55;
        build_model(8, 0, 1);
        @(posedge clk); #1;
        for (int c = 0; c < horizon; c++) begin
            apply_inputs(c);
            @(negedge clk);
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL 8n1_55 cycle %0d got %b expected %b", c, obs, exp_v[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_parity();
        for (int s = 1; s <= 2; s++) begin
            sel = s; n_wr = 1; wr_cyc[0] = 0; wr_word[0] = 'hA3;
            build_model(8, (s == 1) ? 2 : 1, 1);
            @(posedge clk); #1;
            for (int c = 0; c < horizon; c++) begin
                apply_inputs(c);
                @(negedge clk);
                checks++;
                if (obs !== exp_v[c]) begin
                    errors++;
                    $display("FAIL parity_a3 inst=%0d cycle %0d got %b expected %b", s, c, obs, exp_v[c]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        sel = 0; n_wr = 6;
        for (int i = 0; i < 6; i++) begin
            wr_cyc[i]  = i;
            wr_word[i] = i + 1;
        end
        build_model(8, 0, 1);
        @(posedge clk); #1;
        for (int c = 0; c < horizon; c++) begin
            apply_inputs(c);
            @(negedge clk);
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d got %b expected %b", c, obs, exp_v[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_two_stop();
        sel = 3; n_wr = 2; wr_cyc[0] = 0; wr_word[0] = 'h7F; wr_cyc[1] = 3; wr_word[1] = 'h2A;
        build_model(7, 0, 2);
        @(posedge clk); #1;
        for (int c = 0; c < horizon; c++) begin
            apply_inputs(c);
            @(negedge clk);
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL two_stop cycle %0d got %b expected %b", c, obs, exp_v[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        sel = 0; n_wr = 3;
        wr_cyc[0] = 0; wr_word[0] = 'h3C;
        wr_cyc[1] = 1; wr_word[1] = 'hC3;
        wr_cyc[2] = 2; wr_word[2] = 'h99;
        build_model(8, 0, 1);
        @(posedge clk); #1;
        for (int c = 0; c <= 217; c++) begin
            apply_inputs(c);
            if (c == 217) rst = 1'b1;
            @(negedge clk);
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL abort_pre cycle %0d got %b expected %b", c, obs, exp_v[c]);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b10000) begin
                errors++;
                $display("FAIL abort_post cycle %0d got %b expected 10000", c, obs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_after_reset_zero();
        sel = 0; n_wr = 1; wr_cyc[0] = 0; wr_word[0] = 'h00;
        build_model(8, 0, 1);
        @(posedge clk); #1;
        for (int c = 0; c < horizon; c++) begin
            apply_inputs(c);
            @(negedge clk);
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL zero_after_reset cycle %0d got %b expected %b", c, obs, exp_v[c]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int t;
        for (int s = 0; s < 4; s++) begin
            sel  = s;
            n_wr = 6;
            t    = 0;
            for (int i = 0; i < n_wr; i++) begin
                wr_cyc[i]  = t;
                wr_word[i] = int'($urandom_range(0, 511));
                t += ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(1, 150));
            end
            case (s)
                1:       build_model(8, 2, 1);
                2:       build_model(8, 1, 1);
                3:       build_model(7, 0, 2);
                default: build_model(8, 0, 1);
            endcase
            @(posedge clk); #1;
            for (int c = 0; c < horizon; c++) begin
                apply_inputs(c);
                @(negedge clk);
                checks++;
                if (obs !== exp_v[c]) begin
                    errors++;
                    if (errors < 40)
                        $display("FAIL random inst=%0d cycle %0d got %b expected %b", s, c, obs, exp_v[c]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_two_stop();
        test_reset_abort();
        test_after_reset_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
